// File: rtl/tpu_pkg.sv
// tpu_pkg: shared array constants, writeback FSM states and int8 saturation
package tpu_pkg;
    localparam int LANES  = 16;
    localparam int ACC_W  = 20;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} wb_state_t;

    function automatic logic [DATA_W-1:0] sat8(input logic signed [20:0] v);
        return v > 21'sd127 ? 8'h7f : v < -21'sd128 ? 8'h80 : v[7:0];
    endfunction
endpackage

// File: rtl/requant_lane.sv
// requant_lane: one lane of round-half-up arithmetic shift and int8 saturation
module requant_lane
    import tpu_pkg::*;
(
    input  logic [ACC_W-1:0]  acc,
    input  logic [4:0]        shift,
    output logic [DATA_W-1:0] q
);
    logic [4:0] s;
    logic signed [ACC_W:0] r, x;

    always_comb begin
        s = shift > 5'd19 ? 5'd19 : shift;
        r = s == 5'd0 ? '0 : 21'sd1 <<< (s - 5'd1);
        x = ($signed({acc[ACC_W-1], acc}) + r) >>> s;
        q = sat8(x);
    end
endmodule

// File: rtl/result_writeback.sv
// result_writeback: drains accumulator rows, requantizes to int8 and writes them to the unified buffer
module result_writeback
    import tpu_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [4:0]                num_rows,
    input  logic [4:0]                shift,
    input  logic                      acc_empty,
    output logic                      acc_rd_en,
    input  logic [LANES*ACC_W-1:0]    acc_din,
    output logic                      ub_wea,
    output logic [ADDR_W-1:0]         ub_addra,
    output logic [LANES*DATA_W-1:0]   ub_dina,
    output logic                      busy,
    output logic                      done
);
    wb_state_t state, nxt;
    logic [4:0] issued, written, rows, shf;
    logic [ADDR_W-1:0] base;
    logic v1, go;
    logic [LANES*DATA_W-1:0] qrow;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        requant_lane u_lane (
            .acc   (acc_din[ACC_W*i +: ACC_W]),
            .shift (shf),
            .q     (qrow[DATA_W*i +: DATA_W])
        );
    end

    always_comb begin
        nxt = state;
        go = state == IDLE && start && !done;
        acc_rd_en = state == RUN && !acc_empty && issued < rows;
        case (state)
            IDLE:    nxt = go ? (num_rows == 5'd0 ? DONE : RUN) : IDLE;
            RUN:     nxt = issued + 5'(acc_rd_en) == rows ? FLUSH : RUN;
            FLUSH:   nxt = written + 5'(v1) == rows ? DONE : FLUSH;
            default: nxt = IDLE;
        endcase
    end

    // done is registered one cycle behind DONE so busy covers the pulse
    assign busy = state != IDLE || done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            issued   <= '0;
            written  <= '0;
            rows     <= '0;
            shf      <= '0;
            base     <= '0;
            v1       <= 1'b0;
            ub_wea   <= 1'b0;
            ub_addra <= '0;
            ub_dina  <= '0;
            done     <= 1'b0;
        end else begin
            state  <= nxt;
            v1     <= acc_rd_en;
            ub_wea <= v1;
            done   <= state == DONE;
            issued <= go ? '0 : issued + 5'(acc_rd_en);
            if (go) begin
                base <= base_addr;
                rows <= num_rows;
                shf  <= shift;
            end
            if (go) begin
                written <= '0;
            end else if (v1) begin
                written  <= written + 5'd1;
                ub_addra <= base + ADDR_W'(written);
                ub_dina  <= qrow;
            end
        end
    end
endmodule

// File: tb/tb_result_writeback.sv
// tb_result_writeback: randomized self-checking bench with a behavioural FIFO and requant model
module tb_result_writeback;
    logic clk = 1'b0;
    logic reset, start, acc_empty, acc_rd_en, ub_wea, busy, done;
    logic [7:0] base_addr, ub_addra;
    logic [4:0] num_rows, shift;
    logic [319:0] acc_din;
    logic [127:0] ub_dina;

    int checks = 0, failures = 0, cyc = 0;
    logic [319:0] mem [0:1023];
    int wp = 0, rp = 0, pops = 0;
    logic [7:0] oa [0:4095];
    logic [127:0] od [0:4095];
    int oc [0:4095];
    int ow = 0, done_cnt = 0, done_cyc = 0;
    logic [319:0] pend [$];
    int P, w0, nw, np, dcy;
    logic bd;

    result_writeback dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .num_rows(num_rows), .shift(shift), .acc_empty(acc_empty),
        .acc_rd_en(acc_rd_en), .acc_din(acc_din), .ub_wea(ub_wea),
        .ub_addra(ub_addra), .ub_dina(ub_dina), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    assign acc_empty = rp == wp;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (acc_rd_en) pops <= pops + 1;
        if (acc_rd_en && rp != wp) begin
            acc_din <= mem[rp % 1024];
            rp <= rp + 1;
        end
    end

    always @(negedge clk) begin
        if (ub_wea) begin
            oa[ow % 4096] <= ub_addra;
            od[ow % 4096] <= ub_dina;
            oc[ow % 4096] <= cyc;
            ow <= ow + 1;
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
    end

    function automatic logic [127:0] exp_row(input logic [319:0] r, input int sh);
        logic [127:0] o = '0;
        longint d = 1;
        d = d << (sh > 19 ? 19 : sh);
        for (int i = 0; i < 16; i++) begin
            logic signed [19:0] a = r[20*i +: 20];
            longint n = longint'(a) + d / 2;
            longint q = n / d;
            if (n < 0 && q * d != n) q = q - 1;
            if (q > 127) q = 127;
            if (q < -128) q = -128;
            o[8*i +: 8] = q[7:0];
        end
        return o;
    endfunction

    function automatic logic [319:0] rnd_row();
        logic [319:0] o;
        for (int i = 0; i < 10; i++) o[32*i +: 32] = $urandom;
        return o;
    endfunction

    task automatic push_rows(input int from, input int upto);
        for (int i = from; i < upto && i < pend.size(); i++) begin
            mem[wp % 1024] = pend[i];
            wp++;
        end
    endtask

    task automatic run(input string nm, input logic [7:0] b, input logic [4:0] n, input logic [4:0] sh,
                       input int pre, input int dly, input int poke);
        int got = 0;
        int d0, p0;
        push_rows(0, pre);
        @(negedge clk); #1;
        w0 = ow; p0 = pops; d0 = done_cnt; bd = 1'b0;
        base_addr = b; num_rows = n; shift = sh; start = 1'b1; P = cyc;
        for (int t = 1; t <= 300 && got == 0; t++) begin
            @(negedge clk); #1;
            if (t == 1) start = 1'b0;
            if (t == poke) begin
                start = 1'b1; base_addr = 8'h80; num_rows = 5'd2; shift = 5'd0;
            end
            if (t == poke + 1) start = 1'b0;
            if (t == dly) push_rows(pre, pend.size());
            if (done_cnt != d0) begin
                got = 1;
                bd = busy;
            end
        end
        start = 1'b0;
        checks++;
        if (got == 0) begin
            failures++;
            $display("FAIL %s_timeout: done not seen, required within 300 cycles", nm);
        end
        repeat (2) @(negedge clk);
        #1;
        nw = ow - w0; np = pops - p0; dcy = done_cyc;
        wp = rp;
        pend.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; shift = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ub_wea, busy, done, acc_rd_en} !== 4'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 0000", {ub_wea, busy, done, acc_rd_en});
        end
        checks++;
        if ({ub_addra, ub_dina} !== 136'b0) begin
            failures++;
            $display("FAIL reset_data: got addr %h data %h required 0", ub_addra, ub_dina);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, ub_wea, acc_rd_en} !== 3'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got %b required 000", {busy, ub_wea, acc_rd_en});
        end
    endtask

    task automatic test_basic();
        for (int r = 0; r < 6; r++) begin
            logic [19:0] rv = 20'(r);
            pend.push_back({16{rv}});
        end
        run("basic", 8'h10, 5'd4, 5'd0, 6, 0, 0);
        checks++;
        if (nw !== 4 || np !== 4) begin
            failures++;
            $display("FAIL basic_count: got writes %0d pops %0d required 4 4", nw, np);
        end
        checks++;
        if (dcy !== P + 7) begin
            failures++;
            $display("FAIL basic_done_cycle: got %0d required %0d", dcy - P, 7);
        end
        checks++;
        if (bd !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: got at_done %b after %b required 1 0", bd, busy);
        end
        for (int k = 0; k < (nw < 4 ? nw : 4); k++) begin
            logic [7:0] kv = 8'(k);
            checks++;
            if (oa[w0+k] !== 8'h10 + kv || od[w0+k] !== {16{kv}} || oc[w0+k] !== P + 3 + k) begin
                failures++;
                $display("FAIL basic_write%0d: got addr %h data %h cyc %0d required %h %h %0d",
                         k, oa[w0+k], od[w0+k], oc[w0+k] - P, 8'h10 + kv, {16{kv}}, 3 + k);
            end
        end
    endtask

    task automatic test_round_sat();
        int v [6] = '{40, -40, 2047, -2100, 8, -9};
        int e [6] = '{3, -2, 127, -128, 1, -1};
        logic [319:0] row = '0;
        logic [127:0] ex = '0;
        for (int i = 0; i < 6; i++) begin
            row[20*i +: 20] = 20'(v[i]);
            ex[8*i +: 8] = 8'(e[i]);
        end
        pend.push_back(row);
        run("round", 8'h20, 5'd1, 5'd4, 1, 0, 0);
        checks++;
        if (nw !== 1 || od[w0] !== ex || oa[w0] !== 8'h20) begin
            failures++;
            $display("FAIL round_sat: got n %0d addr %h data %h required 1 20 %h", nw, oa[w0], od[w0], ex);
        end
    endtask

    task automatic test_empty_stall();
        int ec [3] = '{3, 9, 10};
        logic [319:0] rw [3];
        for (int i = 0; i < 3; i++) begin
            rw[i] = rnd_row();
            pend.push_back(rw[i]);
        end
        run("stall", 8'h30, 5'd3, 5'd0, 1, 7, 0);
        checks++;
        if (nw !== 3 || np !== 3 || dcy !== P + 11) begin
            failures++;
            $display("FAIL stall_count: got writes %0d pops %0d done %0d required 3 3 11", nw, np, dcy - P);
        end
        for (int k = 0; k < (nw < 3 ? nw : 3); k++) begin
            logic [7:0] ea = 8'(8'h30 + k);
            checks++;
            if (oa[w0+k] !== ea || od[w0+k] !== exp_row(rw[k], 0) || oc[w0+k] !== P + ec[k]) begin
                failures++;
                $display("FAIL stall_write%0d: got addr %h cyc %0d data %h required %h %0d %h",
                         k, oa[w0+k], oc[w0+k] - P, od[w0+k], ea, ec[k], exp_row(rw[k], 0));
            end
        end
    endtask

    task automatic check_stream(input string nm, input logic [7:0] b, input int n, input int sh,
                                input logic [319:0] rw [$]);
        int bad = 0;
        checks++;
        if (nw !== n || np !== n || dcy !== P + n + 3) begin
            failures++;
            $display("FAIL %s_count: got writes %0d pops %0d done %0d required %0d %0d %0d",
                     nm, nw, np, dcy - P, n, n, n + 3);
        end
        for (int k = 0; k < (nw < n ? nw : n); k++) begin
            logic [7:0] ea = b + 8'(k);
            if (oa[w0+k] !== ea || od[w0+k] !== exp_row(rw[k], sh) || oc[w0+k] !== P + 3 + k) begin
                bad++;
                if (bad == 1)
                    $display("FAIL %s_write%0d: got addr %h cyc %0d data %h required %h %0d %h",
                             nm, k, oa[w0+k], oc[w0+k] - P, od[w0+k], ea, 3 + k, exp_row(rw[k], sh));
            end
        end
        checks++;
        if (bad != 0) failures++;
    endtask

    task automatic test_wrap();
        logic [319:0] rw [$];
        int sh = $urandom_range(0, 24);
        for (int i = 0; i < 18; i++) begin
            rw.push_back(rnd_row());
            pend.push_back(rw[i]);
        end
        run("wrap", 8'd250, 5'd16, 5'(sh), 18, 0, 0);
        check_stream("wrap", 8'd250, 16, sh, rw);
    endtask

    task automatic test_zero_rows();
        pend.push_back(rnd_row());
        pend.push_back(rnd_row());
        run("zero", 8'h55, 5'd0, 5'd0, 2, 0, 0);
        checks++;
        if (nw !== 0 || np !== 0 || dcy !== P + 2) begin
            failures++;
            $display("FAIL zero_rows: got writes %0d pops %0d done %0d required 0 0 2", nw, np, dcy - P);
        end
    endtask

    task automatic test_reset_mid();
        logic [319:0] rw [$];
        int d0;
        for (int i = 0; i < 8; i++) pend.push_back(rnd_row());
        push_rows(0, 8);
        pend.delete();
        @(negedge clk); #1;
        w0 = ow; d0 = done_cnt;
        base_addr = 8'h60; num_rows = 5'd8; shift = 5'd1; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 50 && ow - w0 < 2; t++) begin
            @(negedge clk); #1;
        end
        checks++;
        if (ow - w0 < 2) begin
            failures++;
            $display("FAIL reset_mid_progress: got writes %0d required 2", ow - w0);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({ub_wea, busy, done, acc_rd_en} !== 4'b0 || {ub_addra, ub_dina} !== 136'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs: got ctrl %b addr %h data %h required 0",
                     {ub_wea, busy, done, acc_rd_en}, ub_addra, ub_dina);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_no_done: got dones %0d busy %b required 0 0", done_cnt - d0, busy);
        end
        wp = rp;
        for (int i = 0; i < 3; i++) begin
            rw.push_back(rnd_row());
            pend.push_back(rw[i]);
        end
        run("after_reset", 8'h70, 5'd3, 5'd3, 3, 0, 0);
        check_stream("after_reset", 8'h70, 3, 3, rw);
    endtask

    task automatic test_busy_start();
        logic [319:0] rw [$];
        for (int i = 0; i < 8; i++) begin
            rw.push_back(rnd_row());
            pend.push_back(rw[i]);
        end
        run("busy_start", 8'h40, 5'd6, 5'd2, 8, 0, 3);
        check_stream("busy_start", 8'h40, 6, 2, rw);
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            logic [319:0] rw [$];
            logic [7:0] b = 8'($urandom);
            int n = $urandom_range(1, 16);
            int sh = $urandom_range(0, 24);
            int ex = $urandom_range(0, 3);
            for (int i = 0; i < n + ex; i++) begin
                rw.push_back(rnd_row());
                pend.push_back(rw[i]);
            end
            run("random", b, 5'(n), 5'(sh), n + ex, 0, 0);
            check_stream("random", b, n, sh, rw);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_sat();
        test_empty_stall();
        test_wrap();
        test_zero_rows();
        test_reset_mid();
        test_busy_start();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
